// File: rtl/npc_mem_arbiter.sv
// npc_mem_arbiter: shares one single-port memory bus between instruction
// fetch (read-only) and load/store (read/write). Only one transaction is
// outstanding at a time. A starvation guard stops LS from locking out IF,
// and a response watchdog completes a hung transaction with an error.
module npc_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  // instruction fetch port
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_err_o,
  // load/store port
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_wmask_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                ls_err_o,
  // memory bus
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  // core stall
  output logic                hold_flag_o
);

  localparam int MASK_W = DATA_W / 8;
  localparam int SW     = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t        state;
  owner_t        owner;
  logic [SW-1:0] starve_cnt;
  logic [15:0]   tmo_cnt;

  logic ls_wins;
  logic resp;
  logic tmo_fire;
  logic bus_gnt;
  logic done;

  // LS has default priority; IF is forced once LS has won STARVE_MAX times
  // in a row while IF was waiting.
  assign ls_wins  = ls_req_i && !((starve_cnt == SW'(STARVE_MAX)) && if_req_i);

  // A real response in the same cycle as the watchdog expiry wins.
  assign resp     = (state == S_WAIT) && mem_rvalid_i;
  assign tmo_fire = (state != S_IDLE) && (tmo_cnt == 16'(TIMEOUT)) && !resp;
  assign bus_gnt  = (state == S_REQ) && mem_gnt_i && !tmo_fire;
  assign done     = resp || tmo_fire;

  // Route the handshake and response to whichever requester owns the bus.
  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // if/else below can leave a value held, which would infer a latch.
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_err_o    = 1'b0;
    if_rdata_o  = '0;
    ls_gnt_o    = 1'b0;
    ls_rvalid_o = 1'b0;
    ls_err_o    = 1'b0;
    ls_rdata_o  = '0;
    if (owner == OWN_IF) begin
      if_gnt_o    = bus_gnt;
      if_rvalid_o = done;
      if_err_o    = tmo_fire;
      if_rdata_o  = resp ? mem_rdata_i : '0;
    end else begin
      ls_gnt_o    = bus_gnt;
      ls_rvalid_o = done;
      ls_err_o    = tmo_fire;
      ls_rdata_o  = resp ? mem_rdata_i : '0;
    end
  end

  // Stall the core while its load/store is unresolved; forced low in reset.
  assign hold_flag_o = rst_n && ls_req_i && !ls_rvalid_o;

  // Transaction FSM with registered memory-bus outputs and both counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the bus datapath registers are reset as well as the control
      // state, so every mem_* output reads zero while the core is in reset.
      state       <= S_IDLE;
      owner       <= OWN_IF;
      starve_cnt  <= '0;
      tmo_cnt     <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wmask_o <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order in this block.
      case (state)
        S_IDLE: begin
          if (if_req_i || ls_req_i) begin
            state     <= S_REQ;
            mem_req_o <= 1'b1;
            tmo_cnt   <= '0;
            if (ls_wins) begin
              owner       <= OWN_LS;
              mem_we_o    <= ls_we_i;
              mem_addr_o  <= ls_addr_i;
              mem_wdata_o <= ls_wdata_i;
              mem_wmask_o <= ls_we_i ? ls_wmask_i : MASK_W'(0);
              if (if_req_i && (starve_cnt != SW'(STARVE_MAX)))
                starve_cnt <= starve_cnt + 1'b1;
            end else begin
              owner       <= OWN_IF;
              mem_we_o    <= 1'b0;
              mem_addr_o  <= if_addr_i;
              mem_wdata_o <= '0;
              mem_wmask_o <= '0;
              starve_cnt  <= '0;
            end
          end
        end
        S_REQ: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (tmo_fire) begin
            state     <= S_IDLE;
            mem_req_o <= 1'b0;
          end else if (mem_gnt_i) begin
            state     <= S_WAIT;
            mem_req_o <= 1'b0;
          end
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// Directed testbench for npc_mem_arbiter (TIMEOUT = 8, STARVE_MAX = 4).
module tb_npc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o, if_err_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i, ls_we_i;
  logic [31:0] ls_addr_i, ls_wdata_i;
  logic [3:0]  ls_wmask_i;
  logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        hold_flag_o;

  int passed = 0;
  int total  = 0;
  int gnt_pulses;
  logic [5:0] ls_order;

  npc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_wmask_i(ls_wmask_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .hold_flag_o(hold_flag_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0; ls_wmask_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    // ---- reset state ----
    tick(); tick();
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_we", mem_we_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_if_rvalid", if_rvalid_o, 0);
    check("rst_ls_gnt", ls_gnt_o, 0);
    check("rst_hold", hold_flag_o, 0);

    // ---- IF-only, zero-wait memory ----
    tick();
    rst_n = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h8000_0000; #1;
    check("t1_idle_req", mem_req_o, 0);
    tick();                                   // REQ
    if_req_i = 1'b0; mem_gnt_i = 1'b1; #1;
    check("t1_req", mem_req_o, 1);
    check("t1_addr", mem_addr_o, 32'h8000_0000);
    check("t1_we", mem_we_o, 0);
    check("t1_mask", mem_wmask_o, 0);
    check("t1_if_gnt", if_gnt_o, 1);
    check("t1_ls_gnt", ls_gnt_o, 0);
    tick();                                   // WAIT
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0413; #1;
    check("t1_req_drop", mem_req_o, 0);
    check("t1_if_rvalid", if_rvalid_o, 1);
    check("t1_if_rdata", if_rdata_o, 32'h0000_0413);
    check("t1_if_err", if_err_o, 0);
    check("t1_ls_rvalid", ls_rvalid_o, 0);

    // ---- simultaneous IF and LS store: LS goes first ----
    tick();                                   // IDLE
    mem_rvalid_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h8000_0004;
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 32'h8000_1000;
    ls_wdata_i = 32'hDEAD_BEEF; ls_wmask_i = 4'hF; #1;
    check("t2_if_rvalid_gone", if_rvalid_o, 0);
    check("t2_hold_idle", hold_flag_o, 1);
    tick();                                   // REQ (LS)
    mem_gnt_i = 1'b1; #1;
    check("t2_we", mem_we_o, 1);
    check("t2_mask", mem_wmask_o, 4'hF);
    check("t2_addr", mem_addr_o, 32'h8000_1000);
    check("t2_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    check("t2_ls_gnt", ls_gnt_o, 1);
    check("t2_if_gnt", if_gnt_o, 0);
    check("t2_hold_req", hold_flag_o, 1);
    tick();                                   // WAIT
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_5555; #1;
    check("t2_ls_rvalid", ls_rvalid_o, 1);
    check("t2_hold_rvalid", hold_flag_o, 0);
    tick();                                   // IDLE: IF alone now
    mem_rvalid_i = 1'b0; ls_req_i = 1'b0; #1;
    check("t2_ls_rvalid_gone", ls_rvalid_o, 0);
    tick();                                   // REQ (IF)
    if_req_i = 1'b0; mem_gnt_i = 1'b1; #1;
    check("t2_if_addr", mem_addr_o, 32'h8000_0004);
    check("t2_if_we", mem_we_o, 0);
    check("t2_if_mask", mem_wmask_o, 0);
    check("t2_if_gnt2", if_gnt_o, 1);
    tick();                                   // WAIT
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013; #1;
    check("t2_if_rvalid", if_rvalid_o, 1);
    check("t2_if_rdata", if_rdata_o, 32'h0000_0013);

    // ---- starvation guard: LS LS LS LS IF LS ----
    tick();                                   // IDLE
    mem_rvalid_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h8000_0008;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h8000_3000; #1;
    ls_order = 6'b10_1111;                    // bit i = 1 when LS should win grant i
    for (int i = 0; i < 6; i++) begin
      tick();                                 // REQ
      mem_gnt_i = 1'b1; #1;
      check($sformatf("t3_ls_gnt_%0d", i), ls_gnt_o, ls_order[i]);
      check($sformatf("t3_if_gnt_%0d", i), if_gnt_o, !ls_order[i]);
      check($sformatf("t3_addr_%0d", i), mem_addr_o,
            ls_order[i] ? 32'h8000_3000 : 32'h8000_0008);
      tick();                                 // WAIT
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; #1;
      tick();                                 // IDLE
      mem_rvalid_i = 1'b0;
      if (i == 5) begin
        if_req_i = 1'b0; ls_req_i = 1'b0;
      end
      #1;
    end

    // ---- watchdog: LS load granted, never answered ----
    tick();                                   // still IDLE
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h8000_2000; #1;
    tick();                                   // r0: mem_req_o rises
    ls_req_i = 1'b0; mem_gnt_i = 1'b1; #1;
    check("t4_req_rise", mem_req_o, 1);
    check("t4_ls_gnt", ls_gnt_o, 1);
    tick();                                   // r1
    mem_gnt_i = 1'b0; mem_rdata_i = 32'hFFFF_FFFF;
    for (int k = 1; k < 8; k++) begin
      #1;
      check($sformatf("t4_no_rvalid_%0d", k), ls_rvalid_o, 0);
      tick();
    end
    #1;                                       // r8
    check("t4_tmo_rvalid", ls_rvalid_o, 1);
    check("t4_tmo_err", ls_err_o, 1);
    check("t4_tmo_rdata", ls_rdata_o, 0);
    check("t4_tmo_if", if_rvalid_o, 0);
    tick();                                   // IDLE: late response
    mem_rvalid_i = 1'b1; #1;
    check("t4_late_rvalid", ls_rvalid_o, 0);
    check("t4_late_err", ls_err_o, 0);
    check("t4_late_req", mem_req_o, 0);

    // ---- grant wait states ----
    tick();
    mem_rvalid_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h8000_0100; #1;
    tick();                                   // REQ
    if_req_i = 1'b0; if_addr_i = 32'hABCD_0000;
    gnt_pulses = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (if_gnt_o === 1'b1) gnt_pulses++;
      check($sformatf("t5_addr_%0d", k), mem_addr_o, 32'h8000_0100);
      check($sformatf("t5_wdata_%0d", k), mem_wdata_o, 0);
      check($sformatf("t5_req_%0d", k), mem_req_o, 1);
      tick();
    end
    mem_gnt_i = 1'b1; #1;
    if (if_gnt_o === 1'b1) gnt_pulses++;
    check("t5_gnt", if_gnt_o, 1);
    tick();                                   // WAIT
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678; #1;
    if (if_gnt_o === 1'b1) gnt_pulses++;
    check("t5_gnt_pulses", gnt_pulses, 1);
    check("t5_if_rvalid", if_rvalid_o, 1);
    check("t5_if_rdata", if_rdata_o, 32'h1234_5678);

    // ---- reset in the middle of WAIT ----
    tick();
    mem_rvalid_i = 1'b0;
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 32'h8000_4000;
    ls_wdata_i = 32'h1122_3344; ls_wmask_i = 4'h3; #1;
    tick();                                   // REQ
    mem_gnt_i = 1'b1; #1;
    tick();                                   // WAIT
    mem_gnt_i = 1'b0; #1;
    check("t6_hold_wait", hold_flag_o, 1);
    check("t6_we_wait", mem_we_o, 1);
    #2;
    rst_n = 1'b0; #1;
    check("t6_rst_req", mem_req_o, 0);
    check("t6_rst_we", mem_we_o, 0);
    check("t6_rst_addr", mem_addr_o, 0);
    check("t6_rst_wdata", mem_wdata_o, 0);
    check("t6_rst_mask", mem_wmask_o, 0);
    check("t6_rst_hold", hold_flag_o, 0);
    mem_rvalid_i = 1'b1; #1;
    check("t6_rst_rvalid", ls_rvalid_o, 0);
    ls_req_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1; #1;
    check("t6_post_ls_rvalid", ls_rvalid_o, 0);
    check("t6_post_if_rvalid", if_rvalid_o, 0);
    tick();
    #1;
    check("t6_post2_rvalid", ls_rvalid_o, 0);
    check("t6_post2_req", mem_req_o, 0);
    mem_rvalid_i = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
